// File: rtl/led_scroll_engine.sv
// LED bar scroller: prescaled step ticks move a BAR-long lit segment across
// WIDTH columns in bounce, rotate or hold mode, routed to red/green drives.
module led_scroll_engine #(
    parameter int WIDTH = 8,
    parameter int BAR   = 2,
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       speed,
    input  logic [1:0]       mode,
    input  logic [1:0]       color_sel,
    output logic [WIDTH-1:0] red_out,
    output logic [WIDTH-1:0] green_out,
    output logic             step_pulse,
    output logic             edge_pulse
);

    localparam int PW = $clog2(WIDTH);
    localparam logic [PW-1:0] POS_MAX  = PW'(WIDTH - BAR);
    localparam logic [PW-1:0] POS_LAST = PW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] BAR_BASE = {{(WIDTH-BAR){1'b0}}, {BAR{1'b1}}};

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROT_L  = 2'b01,
        MODE_ROT_R  = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    mode_t            cur_mode;
    logic [PW-1:0]    pos, pos_nxt;
    logic             dir, dir_nxt;
    logic             col, col_nxt;
    logic             edge_evt;
    logic [DIV_W-1:0] pre, pre_mask;
    logic             tick;
    logic [2*WIDTH-1:0] wide;
    logic [WIDTH-1:0] pattern;

    assign cur_mode = mode_t'(mode);

    // A tick fires when the low DIV_W-speed prescaler bits are all ones.
    assign pre_mask = {DIV_W{1'b1}} >> speed;
    assign tick     = en & ((pre & pre_mask) == pre_mask);

    always_comb begin
        pos_nxt  = pos;
        dir_nxt  = dir;
        edge_evt = 1'b0;
        case (cur_mode)
            MODE_BOUNCE: begin
                // A bar left past the bounce limit by a rotate mode snaps back quietly.
                if (pos > POS_MAX) begin
                    pos_nxt = POS_MAX;
                    dir_nxt = 1'b0;
                end else if (!dir && pos == '0) begin
                    dir_nxt  = 1'b1;
                    edge_evt = 1'b1;
                end else if (dir && pos == POS_MAX) begin
                    dir_nxt  = 1'b0;
                    edge_evt = 1'b1;
                end else if (dir) begin
                    pos_nxt = pos + PW'(1);
                end else begin
                    pos_nxt = pos - PW'(1);
                end
            end
            MODE_ROT_L: begin
                pos_nxt  = (pos == POS_LAST) ? '0 : pos + PW'(1);
                edge_evt = (pos == POS_LAST);
            end
            MODE_ROT_R: begin
                pos_nxt  = (pos == '0) ? POS_LAST : pos - PW'(1);
                edge_evt = (pos == '0);
            end
            default: begin
                pos_nxt = pos;
            end
        endcase
        col_nxt = col ^ edge_evt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos        <= POS_MAX;
            dir        <= 1'b0;
            col        <= 1'b0;
            pre        <= '0;
            step_pulse <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            if (en) begin
                pre <= pre + DIV_W'(1);
            end
            step_pulse <= tick && (cur_mode != MODE_HOLD);
            edge_pulse <= tick && edge_evt;
            if (tick) begin
                pos <= pos_nxt;
                dir <= dir_nxt;
                col <= col_nxt;
            end
        end
    end

    // Rotating through a double-width vector folds the overflow back to the LSBs.
    assign wide    = {{WIDTH{1'b0}}, BAR_BASE} << pos;
    assign pattern = wide[WIDTH-1:0] | wide[2*WIDTH-1:WIDTH];

    always_comb begin
        red_out   = '0;
        green_out = '0;
        case (color_sel)
            2'b00: red_out = pattern;
            2'b01: green_out = pattern;
            2'b10: begin
                red_out   = pattern;
                green_out = pattern;
            end
            default: begin
                if (col) green_out = pattern;
                else     red_out   = pattern;
            end
        endcase
    end

endmodule

// File: tb/tb_led_scroll_engine.sv
// Directed testbench for led_scroll_engine with WIDTH=8, BAR=2, DIV_W=4.
module tb_led_scroll_engine;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] speed;
    logic [1:0] mode;
    logic [1:0] color_sel;
    logic [7:0] red_out;
    logic [7:0] green_out;
    logic       step_pulse;
    logic       edge_pulse;

    int n_compared;
    int n_mismatched;

    logic [7:0] bounce_seq [0:14] = '{8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h03,
                                      8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'hC0, 8'h60};

    led_scroll_engine #(.WIDTH(8), .BAR(2), .DIV_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .speed      (speed),
        .mode       (mode),
        .color_sel  (color_sel),
        .red_out    (red_out),
        .green_out  (green_out),
        .step_pulse (step_pulse),
        .edge_pulse (edge_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        edges(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        en = 1'b1; speed = 2'd0; mode = 2'b00; color_sel = 2'b00;
        apply_reset();
        edges(16);
        n_compared++;
        if (step_pulse !== 1'b1 || red_out !== 8'h60) begin
            n_mismatched++;
            $display("[TB] FAIL reset_prerun: red=%h step=%b expected red=60 step=1", red_out, step_pulse);
        end
        reset = 1'b0;
        #1;
        n_compared++;
        if (red_out !== 8'hC0 || green_out !== 8'h00 || step_pulse !== 1'b0 || edge_pulse !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_async: red=%h green=%h step=%b edge=%b expected C0 00 0 0",
                     red_out, green_out, step_pulse, edge_pulse);
        end
        edges(2);
        reset = 1'b1;
        edges(15);
        n_compared++;
        if (red_out !== 8'hC0 || step_pulse !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_edge15: red=%h step=%b expected C0 0", red_out, step_pulse);
        end
        edges(1);
        n_compared++;
        if (red_out !== 8'h60 || step_pulse !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_edge16: red=%h step=%b expected 60 1", red_out, step_pulse);
        end
    endtask

    task automatic test_bounce();
        logic exp_edge;
        en = 1'b1; speed = 2'd0; mode = 2'b00; color_sel = 2'b00;
        apply_reset();
        edges(15);
        for (int i = 0; i < 15; i++) begin
            edges(1);
            exp_edge = (i == 6) || (i == 13);
            n_compared++;
            if (red_out !== bounce_seq[i] || green_out !== 8'h00 ||
                step_pulse !== 1'b1 || edge_pulse !== exp_edge) begin
                n_mismatched++;
                $display("[TB] FAIL bounce_tick%0d: red=%h green=%h step=%b edge=%b expected %h 00 1 %b",
                         i, red_out, green_out, step_pulse, edge_pulse, bounce_seq[i], exp_edge);
            end
            edges(1);
            n_compared++;
            if (step_pulse !== 1'b0 || edge_pulse !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL bounce_pulse_width%0d: step=%b edge=%b expected 0 0",
                         i, step_pulse, edge_pulse);
            end
            edges(14);
        end
    endtask

    task automatic test_rotate();
        logic [7:0] exp_left [0:2] = '{8'h81, 8'h03, 8'h06};
        logic       exp_ledge [0:2] = '{1'b0, 1'b1, 1'b0};
        en = 1'b1; speed = 2'd0; mode = 2'b01; color_sel = 2'b00;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            edges(16);
            n_compared++;
            if (red_out !== exp_left[i] || edge_pulse !== exp_ledge[i] || step_pulse !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL rotl_tick%0d: red=%h edge=%b step=%b expected %h %b 1",
                         i, red_out, edge_pulse, step_pulse, exp_left[i], exp_ledge[i]);
            end
        end
        mode = 2'b10;
        apply_reset();
        edges(16);
        n_compared++;
        if (red_out !== 8'h60 || edge_pulse !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rotr_first: red=%h edge=%b expected 60 0", red_out, edge_pulse);
        end
        mode = 2'b01;
        apply_reset();
        edges(32);
        mode = 2'b10;
        edges(16);
        n_compared++;
        if (red_out !== 8'h81 || edge_pulse !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rotr_wrap: red=%h edge=%b expected 81 1", red_out, edge_pulse);
        end
    endtask

    task automatic test_alt_color();
        en = 1'b1; speed = 2'd0; mode = 2'b00; color_sel = 2'b11;
        apply_reset();
        edges(16 * 6);
        n_compared++;
        if (red_out !== 8'h03 || green_out !== 8'h00) begin
            n_mismatched++;
            $display("[TB] FAIL alt_before_dwell: red=%h green=%h expected 03 00", red_out, green_out);
        end
        edges(16);
        n_compared++;
        if (red_out !== 8'h00 || green_out !== 8'h03 || edge_pulse !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL alt_dwell03: red=%h green=%h edge=%b expected 00 03 1",
                     red_out, green_out, edge_pulse);
        end
        edges(16);
        n_compared++;
        if (red_out !== 8'h00 || green_out !== 8'h06) begin
            n_mismatched++;
            $display("[TB] FAIL alt_green_run: red=%h green=%h expected 00 06", red_out, green_out);
        end
        edges(16 * 6);
        n_compared++;
        if (red_out !== 8'hC0 || green_out !== 8'h00 || edge_pulse !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL alt_dwellC0: red=%h green=%h edge=%b expected C0 00 1",
                     red_out, green_out, edge_pulse);
        end
        color_sel = 2'b10;
        #1;
        n_compared++;
        if (red_out !== 8'hC0 || green_out !== 8'hC0) begin
            n_mismatched++;
            $display("[TB] FAIL color_both: red=%h green=%h expected C0 C0", red_out, green_out);
        end
        color_sel = 2'b01;
        #1;
        n_compared++;
        if (red_out !== 8'h00 || green_out !== 8'hC0) begin
            n_mismatched++;
            $display("[TB] FAIL color_green: red=%h green=%h expected 00 C0", red_out, green_out);
        end
    endtask

    task automatic test_mode_switch();
        en = 1'b1; speed = 2'd0; mode = 2'b01; color_sel = 2'b00;
        apply_reset();
        edges(16);
        n_compared++;
        if (red_out !== 8'h81) begin
            n_mismatched++;
            $display("[TB] FAIL switch_rotl: red=%h expected 81", red_out);
        end
        mode = 2'b00;
        edges(16);
        n_compared++;
        if (red_out !== 8'hC0 || edge_pulse !== 1'b0 || step_pulse !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL switch_snap: red=%h edge=%b step=%b expected C0 0 1",
                     red_out, edge_pulse, step_pulse);
        end
        edges(16);
        n_compared++;
        if (red_out !== 8'h60) begin
            n_mismatched++;
            $display("[TB] FAIL switch_next: red=%h expected 60", red_out);
        end
    endtask

    task automatic test_controls();
        int pulses_seen;
        logic [7:0] exp_fast [0:3] = '{8'hC0, 8'h60, 8'h60, 8'h30};
        logic       exp_fstep [0:3] = '{1'b0, 1'b1, 1'b0, 1'b1};
        en = 1'b1; speed = 2'd0; mode = 2'b00; color_sel = 2'b00;
        apply_reset();
        edges(8);
        en = 1'b0;
        pulses_seen = 0;
        for (int i = 0; i < 50; i++) begin
            edges(1);
            if (step_pulse !== 1'b0 || edge_pulse !== 1'b0 || red_out !== 8'hC0) pulses_seen++;
        end
        n_compared++;
        if (pulses_seen !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL en_freeze: %0d cycles changed, expected 0", pulses_seen);
        end
        en = 1'b1;
        edges(7);
        n_compared++;
        if (red_out !== 8'hC0) begin
            n_mismatched++;
            $display("[TB] FAIL en_resume7: red=%h expected C0", red_out);
        end
        edges(1);
        n_compared++;
        if (red_out !== 8'h60 || step_pulse !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL en_resume8: red=%h step=%b expected 60 1", red_out, step_pulse);
        end
        speed = 2'd3;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            edges(1);
            n_compared++;
            if (red_out !== exp_fast[i] || step_pulse !== exp_fstep[i]) begin
                n_mismatched++;
                $display("[TB] FAIL speed3_edge%0d: red=%h step=%b expected %h %b",
                         i, red_out, step_pulse, exp_fast[i], exp_fstep[i]);
            end
        end
        mode = 2'b11;
        pulses_seen = 0;
        for (int i = 0; i < 20; i++) begin
            edges(1);
            if (step_pulse !== 1'b0 || edge_pulse !== 1'b0 || red_out !== 8'h30) pulses_seen++;
        end
        n_compared++;
        if (pulses_seen !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL hold_mode: %0d cycles changed, expected 0", pulses_seen);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset = 1'b0; en = 1'b0; speed = 2'd0; mode = 2'b00; color_sel = 2'b00;
        #3;
        test_reset();
        test_bounce();
        test_rotate();
        test_alt_color();
        test_mode_switch();
        test_controls();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/led_scroll_engine.md
# led_scroll_engine

Parametrised LED bar scroller that drives the red and green column lines of the display board. It is the next generation of the fixed 8-bit, 2-LED ping-pong scroller, adding parametrised width, bar length and prescaler, plus run-time speed, an enable, four motion modes and four colour modes. An edge-event strobe lets other logic synchronise to bounces and wraps. The built-in prescaler means it connects directly to the board clock, with no external frequency divider.

## Interface
Parameters:
- WIDTH, 8: number of LED columns; WIDTH >= 2.
- BAR, 2: number of lit LEDs in the bar; 1 <= BAR <= WIDTH-1.
- DIV_W, 20: prescaler width; DIV_W >= 4.

Ports:
- clk  in  1  board clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  1 = run prescaler and motion; 0 = freeze all state.
- speed  in  2  step period = 2^(DIV_W-speed) enabled clocks.
- mode  in  2  00 bounce, 01 rotate-left (toward MSB), 10 rotate-right (toward LSB), 11 hold.
- color_sel  in  2  00 red, 01 green, 10 both, 11 alternate on each edge event.
- red_out  out  WIDTH  red column drive, active-high.
- green_out  out  WIDTH  green column drive, active-high.
- step_pulse  out  1  one-clock strobe after every step tick that is not in hold mode.
- edge_pulse  out  1  one-clock strobe after every reversal or wrap.

## Operation
- State:
  - pos: index of the bar's LSB LED, range 0..WIDTH-1.
  - dir: 0 = pos decreasing, 1 = pos increasing.
  - col: 0 = red, 1 = green; used only when color_sel=11.
  - pre: DIV_W-bit prescaler.
- Pattern: bit (pos+k) mod WIDTH is set, for k = 0..BAR-1. In rotate modes the bar straddles the edge (wraps around).
- Colour routing:
  - color_sel 00: red_out = pattern, green_out = 0.
  - 01: red_out = 0, green_out = pattern.
  - 10: both outputs = pattern.
  - 11: the output selected by col carries the pattern; the other is 0.
- Prescaler: pre increments by 1 every clock while en=1 and wraps modulo 2^DIV_W. tick = en & (all low DIV_W-speed bits of pre are 1). A speed change takes effect immediately, with no reset of pre.
- On tick, by mode:
  - Bounce, pos > WIDTH-BAR (entered from a rotate mode): pos <= WIDTH-BAR, dir <= 0. Not an edge event.
  - Bounce, dir=0 and pos=0: pos holds (dwell), dir <= 1. Edge event.
  - Bounce, dir=1 and pos=WIDTH-BAR: pos holds (dwell), dir <= 0. Edge event.
  - Bounce, otherwise: pos moves one step in dir.
  - Rotate-left: pos <= (pos+1) mod WIDTH. Edge event when the new pos = 0.
  - Rotate-right: pos <= pos-1, with 0 -> WIDTH-1. Edge event when the new pos = WIDTH-1.
  - Hold: no state change, no pulses; pre keeps running.
- On an edge event, col toggles. col toggles in every colour mode but is visible only in mode 11.
- dir is unchanged in rotate and hold modes.
- Mode changes apply at the next tick. Changes to color_sel take effect combinationally.

## Timing
- Reset (reset=0, asynchronous):
  - pos = WIDTH-BAR, dir = 0, col = 0, pre = 0.
  - step_pulse = 0, edge_pulse = 0.
  - For color_sel=00 the outputs show the bar at the MSB end (WIDTH=8, BAR=2: red_out = 8'hC0).
- Reset release: the first tick occurs on the 2^(DIV_W-speed)-th enabled rising edge after release.
- pos, dir and col update on the tick edge. The outputs are decoded from registers, so they change immediately after that edge.
- step_pulse and edge_pulse are registered and are high for exactly the one cycle following the tick edge.
- en=0: every register holds and both pulses are 0.
- Reset asserted mid-operation overrides everything immediately. Motion restarts from the reset state.

## Test plan
All cases use WIDTH=8, BAR=2, DIV_W=4, speed=0 (period 16) unless stated otherwise.
- Reset: assert reset low mid-run with color_sel=00 -> red_out=C0, green_out=00, both pulses 0 immediately. After release, the first change to 60 occurs on the 16th edge.
- Bounce: tick sequence C0,60,30,18,0C,06,03,03,06,0C,18,30,60,C0,C0,60. edge_pulse accompanies exactly the repeated 03 and the repeated C0; step_pulse accompanies every tick.
- Rotate-left from reset: C0 -> 81 -> 03 (edge_pulse) -> 06. Rotate-right from reset: C0 -> 60, and from pos 0: 03 -> 81 (edge_pulse).
- Alternate colour, bounce (color_sel=11): red carries the pattern until the 03 dwell. On that dwell, red_out=00, green_out=03. Colour returns to red at the next C0 dwell.
- Mode switch: rotate-left to pos 7 (81), then select bounce -> the next tick gives C0, no edge_pulse, then 60.
- Controls:
  - en=0 for 50 cycles -> outputs and pre are frozen, no pulses.
  - speed=3 -> one tick every 2 clocks.
  - hold mode -> output constant, no pulses.
